// File: rtl/digit_shift_pkg.sv
// Shared types and constants for the digit-position shifter.
// State enum, default widths and direction encodings.
package digit_shift_pkg;

  localparam int IN_W_DEF    = 8;
  localparam int DIGIT_W_DEF = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_shifter_seq.sv
// Handshaked digit-position shifter: places an IN_W operand in a 2*IN_W
// field, one digit per cycle. DIGIT_SHIFTER_BYPASS_EN: one-cycle placement.
module digit_shifter_seq
  import digit_shift_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF,
  localparam int OUT_W   = 2 * IN_W,
  localparam int MAX_DIG = IN_W / DIGIT_W,
  localparam int SH_W    = $clog2(MAX_DIG + 1) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  inp,
  input  logic [SH_W-1:0]  shamt,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] shift_out,
  output logic             shamt_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_acc_nxt;
  logic [SH_W-1:0]  r_cnt;
  logic [SH_W-1:0]  w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic [OUT_W-1:0] r_out;
  logic             w_accept;
  logic             w_bad;
  logic [SH_W-1:0]  w_cnt_ld;
  logic [OUT_W-1:0] w_base;
  logic [OUT_W-1:0] w_step;
  logic             w_load_out;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign shift_out = r_out;
  assign shamt_err = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_bad    = (shamt > SH_W'(MAX_DIG));
  assign w_cnt_ld = w_bad ? '0 : shamt;

  // Base position of the operand before any digit shift.
  always_comb begin
    w_base = '0;
    if (dir == DIR_RIGHT)
      w_base = {inp, {IN_W{1'b0}}};
    else
      w_base = {{IN_W{1'b0}}, inp};
  end

  // One digit step of the held accumulator, logical with zero fill.
  always_comb begin
    w_step = r_acc;
    if (r_dir == DIR_RIGHT)
      w_step = r_acc >> DIGIT_W;
    else
      w_step = r_acc << DIGIT_W;
  end

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_dir_nxt = dir;
          w_err_nxt = w_bad;
`ifdef DIGIT_SHIFTER_BYPASS_EN
          if (dir == DIR_RIGHT)
            w_acc_nxt = w_base >> (int'(w_cnt_ld) * DIGIT_W);
          else
            w_acc_nxt = w_base << (int'(w_cnt_ld) * DIGIT_W);
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
`else
          w_acc_nxt = w_base;
          w_cnt_nxt = w_cnt_ld;
          if (w_cnt_ld == '0)
            w_state_nxt = DONE;
          else
            w_state_nxt = SHIFT;
`endif
        end
      end
      SHIFT: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt - SH_W'(1);
        if (r_cnt <= SH_W'(1))
          w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the result only when entering DONE so it stays put afterwards.
  assign w_load_out = (r_state != DONE) && (w_state_nxt == DONE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dir   <= DIR_LEFT;
      r_err   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_err   <= w_err_nxt;
      if (w_load_out)
        r_out <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_digit_shifter_seq.sv
// Scoreboard bench for digit_shifter_seq (default IN_W=8, DIGIT_W=4).
// Stimulus pushes expected results; a negedge monitor pops on handshake.
module tb_digit_shifter_seq;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int SH_W  = 3;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  inp;
  logic [SH_W-1:0]  shamt;
  logic             dir;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] shift_out;
  logic             shamt_err;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  digit_shifter_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .shamt     (shamt),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift_out (shift_out),
    .shamt_err (shamt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare each delivered result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %0h err %0b, expected nothing",
                 shift_out, shamt_err);
      end else begin
        e = q.pop_front();
        if (shift_out !== e.data || shamt_err !== e.err) begin
          n_fail++;
          $display("FAIL sb_result: got %0h err %0b, expected %0h err %0b",
                   shift_out, shamt_err, e.data, e.err);
        end
      end
    end
  end

  task automatic send(input string name, input logic [IN_W-1:0] a,
                      input logic [SH_W-1:0] s, input logic d,
                      input logic [OUT_W-1:0] ed, input logic ee,
                      input int elat);
    int lat;
    exp_t e;
    e.data = ed;
    e.err  = ee;
    q.push_back(e);
    in_valid = 1'b1;
    inp      = a;
    shamt    = s;
    dir      = d;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(elat));
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    inp       = 8'h99;
    shamt     = 3'd1;
    dir       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_shift_out", 32'(shift_out), 32'd0);
    chk("rst_shamt_err", 32'(shamt_err), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    send("left0", 8'h55, 3'd0, 1'b0, 16'h0055, 1'b0, 1);
    send("left1", 8'h55, 3'd1, 1'b0, 16'h0550, 1'b0, 2);
    send("left2", 8'h55, 3'd2, 1'b0, 16'h5500, 1'b0, 3);
    send("right1", 8'h33, 3'd1, 1'b1, 16'h0330, 1'b0, 2);
    send("right2", 8'h33, 3'd2, 1'b1, 16'h0033, 1'b0, 3);
    send("right0", 8'h33, 3'd0, 1'b1, 16'h3300, 1'b0, 1);
    send("illegal3", 8'hCC, 3'd3, 1'b0, 16'h00CC, 1'b1, 1);
    send("illegal7r", 8'hCC, 3'd7, 1'b1, 16'hCC00, 1'b1, 1);

    // Backpressure with a second request held behind it.
    out_ready = 1'b0;
    begin
      exp_t e;
      int lat;
      e.data = 16'hF000;
      e.err  = 1'b0;
      q.push_back(e);
      in_valid = 1'b1;
      inp      = 8'hF0;
      shamt    = 3'd2;
      dir      = 1'b0;
      @(negedge clk);
      inp   = 8'h01;
      shamt = 3'd0;
      lat   = 1;
      while (!out_valid && lat < 12) begin
        chk("bp_in_ready_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        lat++;
      end
      chk("bp_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
        chk("bp_stable_data", 32'(shift_out), 32'hF000);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      e.data = 16'h0001;
      e.err  = 1'b0;
      q.push_back(e);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_after_in_ready", 32'(in_ready), 32'd1);
      chk("bp_after_valid", 32'(out_valid), 32'd0);
      chk("bp_retained", 32'(shift_out), 32'hF000);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end

    // Reset in the middle of a shift discards the result.
    in_valid = 1'b1;
    inp      = 8'hAC;
    shamt    = 3'd2;
    dir      = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_in_shift", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    send("post_rst", 8'h12, 3'd1, 1'b0, 16'h0120, 1'b0, 2);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
